simd_processor_pipe: RTL and testbench

Parametrised multi-lane SIMD execute unit: a LANES×DATA_W register file plus per-lane ALU behind a two-stage issue pipeline with valid/ready handshake, operand bypass, a multi-cycle multiply and automatic writeback to `rd`. It replaces the single-lane, unpipelined processor datapath and sits between the instruction sequencer (issue side) and the result collector (result side).

---
 rtl/simd_pkg.sv | 24 ++
 rtl/simd_lane_alu.sv | 35 +++
 rtl/simd_processor_pipe.sv | 139 +++++++++++++
 tb/tb_simd_processor_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
// Shared types and defaults for the SIMD execute unit.
// Op encoding, parameter defaults and lane slicing helper.
package simd_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_LANES     = 4;
  localparam int DEF_REG_DEPTH = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_MUL_LAT   = 2;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_BITREV = 3'd2,
    OP_MUL    = 3'd3,
    OP_ADDS   = 3'd4
  } op_t;

  // LSB position of a lane inside a packed vector.
  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/simd_lane_alu.sv
// One-lane combinational ALU of the SIMD execute unit.
// Illegal opcodes produce zero.
module simd_lane_alu
  import simd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] rev;

  // Evaluate the selected operation on one lane.
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      rev[i] = a[DATA_W-1-i];
    end
    y = '0;
    unique case (op_t'(op))
      OP_ADD:    y = sum[DATA_W-1:0];
      OP_SUB:    y = a - b;
      OP_BITREV: y = rev;
      OP_MUL:    y = a * b;
      OP_ADDS:   y = sum[DATA_W] ? '1 : sum[DATA_W-1:0];
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/simd_processor_pipe.sv
// Multi-lane SIMD execute unit: RD/EX pipeline, bypass,
// multi-cycle MUL, register file with external load port.
module simd_processor_pipe
  import simd_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LANES     = DEF_LANES,
  parameter int REG_DEPTH = DEF_REG_DEPTH,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MUL_LAT   = DEF_MUL_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              op,
  input  logic [ADDR_W-1:0]       rs1,
  input  logic [ADDR_W-1:0]       rs2,
  input  logic [ADDR_W-1:0]       rd,
  input  logic                    ld_en,
  input  logic [ADDR_W-1:0]       ld_addr,
  input  logic [LANES*DATA_W-1:0] ld_data,
  output logic                    res_valid,
  output logic [LANES*DATA_W-1:0] res_data,
  output logic [ADDR_W-1:0]       res_rd,
  output logic                    res_err
);

  localparam int VEC_W = LANES * DATA_W;
  localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EX1  = 2'd1;
  localparam logic [1:0] S_MULW = 2'd2;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        ex_op;
  logic [VEC_W-1:0]  ex_a;
  logic [VEC_W-1:0]  ex_b;
  logic [ADDR_W-1:0] ex_rd;
  logic [VEC_W-1:0]  ex_y;
  logic [VEC_W-1:0]  opa;
  logic [VEC_W-1:0]  opb;
  logic [VEC_W-1:0]  rf [REG_DEPTH];

  logic accept;
  logic done;
  logic legal;
  logic wb;

  assign in_ready = !rst && !(state == S_MULW && cnt != '0);
  assign accept   = in_valid && in_ready;
  assign done     = (state == S_EX1) ||
                    (state == S_MULW && cnt == '0);
  assign legal    = ex_op <= 3'(OP_ADDS);
  assign wb       = done && legal;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    simd_lane_alu #(
      .DATA_W (DATA_W)
    ) u_alu (
      .op (ex_op),
      .a  (ex_a[lane_lsb(g, DATA_W) +: DATA_W]),
      .b  (ex_b[lane_lsb(g, DATA_W) +: DATA_W]),
      .y  (ex_y[lane_lsb(g, DATA_W) +: DATA_W])
    );
  end

  // Operand read with bypass from a completing EX result.
  always_comb begin
    opa = rf[rs1];
    opb = rf[rs2];
    if (wb && ex_rd == rs1) opa = ex_y;
    if (wb && ex_rd == rs2) opb = ex_y;
  end

  // EX state machine, MUL countdown and operand capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      ex_op <= '0;
      ex_a  <= '0;
      ex_b  <= '0;
      ex_rd <= '0;
    end else if (accept) begin
      ex_op <= op;
      ex_a  <= opa;
      ex_b  <= opb;
      ex_rd <= rd;
      if (op == 3'(OP_MUL)) begin
        state <= S_MULW;
        cnt   <= CNT_W'(MUL_LAT - 1);
      end else begin
        state <= S_EX1;
        cnt   <= '0;
      end
    end else if (done) begin
      state <= S_IDLE;
    end else if (state == S_MULW) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Register file: writeback has priority over a same-address load.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (ld_en && !(wb && ld_addr == ex_rd)) begin
        rf[ld_addr] <= ld_data;
      end
      if (wb) begin
        rf[ex_rd] <= ex_y;
      end
    end
  end

  // Registered result pulse on EX completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_rd    <= '0;
      res_err   <= 1'b0;
    end else begin
      res_valid <= done;
      if (done) begin
        res_data <= legal ? ex_y : '0;
        res_rd   <= ex_rd;
        res_err  <= !legal;
      end
    end
  end

endmodule

// File: tb/tb_simd_processor_pipe.sv
// Self-checking bench for simd_processor_pipe.
// Sequential reference model plus result scoreboard.
module tb_simd_processor_pipe;

  localparam int DW  = 16;
  localparam int NL  = 4;
  localparam int ML  = 2;
  localparam int VW  = DW * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    op;
  logic [4:0]    rs1, rs2, rd;
  logic          ld_en;
  logic [4:0]    ld_addr;
  logic [VW-1:0] ld_data;
  logic          res_valid;
  logic [VW-1:0] res_data;
  logic [4:0]    res_rd;
  logic          res_err;

  simd_processor_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .res_err   (res_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [VW-1:0] data;
    logic [4:0]    rd;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t q[$];
  int unsigned m [32][NL];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got,
                     input logic [VW-1:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lane_ref(input int o,
      input int unsigned a, input int unsigned b);
    longint unsigned r;
    r = 0;
    case (o)
      0: r = (a + b) % 65536;
      1: r = (a + 65536 - b) % 65536;
      2: for (int i = 0; i < DW; i++)
           if (((a >> i) & 1) != 0) r = r + (64'd1 << (DW - 1 - i));
      3: r = (longint'(a) * longint'(b)) % 65536;
      4: r = (a + b > 65535) ? 65535 : a + b;
      default: r = 0;
    endcase
    return int'(r);
  endfunction

  function automatic logic [VW-1:0] pack(input int unsigned v [NL]);
    logic [VW-1:0] p;
    p = '0;
    for (int i = 0; i < NL; i++) p[i*DW +: DW] = DW'(v[i]);
    return p;
  endfunction

  // Result monitor: every pulse must match the oldest pending op.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      chk("spurious_result", 1'(q.size() != 0), 1'b1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("res_data", res_data, e.data);
        chk("res_rd", VW'(res_rd), VW'(e.rd));
        chk("res_err", VW'(res_err), VW'(e.err));
        chk("res_cycle", VW'(cyc), VW'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int o, input int a, input int b,
                       input int d, output int waited);
    exp_t e;
    int unsigned v [NL];
    int k;
    in_valid = 1'b1;
    op  = 3'(o);
    rs1 = 5'(a);
    rs2 = 5'(b);
    rd  = 5'(d);
    k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    chk("ready_timeout", VW'(in_ready), VW'(1));
    waited = k;
    for (int i = 0; i < NL; i++) v[i] = lane_ref(o, m[a][i], m[b][i]);
    e.data = (o <= 4) ? pack(v) : '0;
    e.rd   = 5'(d);
    e.err  = (o > 4);
    e.cyc  = cyc + ((o == 3) ? 1 + ML : 2);
    q.push_back(e);
    if (o <= 4) for (int i = 0; i < NL; i++) m[d][i] = v[i];
    step();
    in_valid = 1'b0;
  endtask

  task automatic load(input int addr, input logic [VW-1:0] data);
    ld_en   = 1'b1;
    ld_addr = 5'(addr);
    ld_data = data;
    for (int i = 0; i < NL; i++) m[addr][i] = data[i*DW +: DW];
    step();
    ld_en = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      step();
      k++;
    end
    chk("drain_timeout", VW'(q.size()), '0);
  endtask

  initial begin
    int w;
    logic [VW-1:0] rv;
    for (int r = 0; r < 32; r++)
      for (int i = 0; i < NL; i++) m[r][i] = 0;
    rst = 1'b1; in_valid = 1'b0; op = '0;
    rs1 = '0; rs2 = '0; rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    repeat (3) step();
    chk("rst_ready", VW'(in_ready), '0);
    chk("rst_valid", VW'(res_valid), '0);
    chk("rst_data", res_data, '0);
    chk("rst_rd", VW'(res_rd), '0);
    chk("rst_err", VW'(res_err), '0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", VW'(in_ready), VW'(1));

    // Directed cases
    load(1, {16'hFFFF, 16'd3, 16'd2, 16'd1});
    load(2, {16'd1, 16'd1, 16'd1, 16'd1});
    issue(0, 1, 2, 3, w);
    drain();
    issue(4, 1, 2, 4, w);
    issue(1, 2, 1, 5, w);
    issue(2, 1, 1, 11, w);
    drain();
    issue(0, 1, 2, 3, w);
    issue(0, 3, 2, 6, w);
    drain();
    issue(3, 1, 1, 7, w);
    issue(0, 7, 2, 12, w);
    chk("mul_stall_cycles", VW'(w), VW'(ML - 1));
    drain();

    // Load collides with writeback: writeback wins
    issue(0, 1, 1, 3, w);
    ld_en = 1'b1; ld_addr = 5'd3; ld_data = {NL{16'hBEEF}};
    step();
    ld_en = 1'b0;
    drain();
    issue(0, 3, 0, 13, w);
    drain();
    // Load to another address alongside a writeback
    issue(1, 1, 2, 3, w);
    load(9, {16'h0004, 16'h0003, 16'h0002, 16'h0001});
    drain();
    issue(0, 9, 3, 14, w);
    issue(6, 1, 2, 2, w);
    issue(0, 2, 2, 15, w);
    drain();

    // Random traffic
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        drain();
        rv = {$urandom, $urandom};
        load(int'($urandom_range(0, 31)), rv);
      end else begin
        int o;
        o = ($urandom_range(0, 15) == 0) ? int'($urandom_range(5, 7))
                                         : int'($urandom_range(0, 4));
        issue(o, int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), w);
        if ($urandom_range(0, 3) == 0) step();
      end
    end
    drain();

    // Reset in the middle of a MUL discards it
    issue(3, 1, 1, 8, w);
    rst = 1'b1;
    #1;
    chk("ready_in_rst", VW'(in_ready), '0);
    q.delete();
    for (int r = 0; r < 32; r++)
      for (int i = 0; i < NL; i++) m[r][i] = 0;
    repeat (3) step();
    chk("rst2_valid", VW'(res_valid), '0);
    rst = 1'b0;
    #1;
    chk("ready_post_rst", VW'(in_ready), VW'(1));
    repeat (4) step();
    issue(0, 1, 8, 10, w);
    issue(4, 9, 3, 16, w);
    issue(0, 7, 2, 17, w);
    drain();

    chk("queue_empty", VW'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
